// File: rtl/sync_ram_sp_ctrl.sv
// Synchronous single-port RAM controller: valid/ready requests, registered read data,
// one-cycle response strobe, clear sweep on reset or request, out-of-range detection.
module sync_ram_sp_ctrl #(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          ADDR_WIDTH = 4,
    parameter int unsigned          RAM_SIZE   = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  clear_req,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned CMP_W = ADDR_WIDTH + 1;
    localparam int unsigned PTR_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(RAM_SIZE - 1);
    localparam logic [CMP_W-1:0]      SIZE_CMP = CMP_W'(RAM_SIZE);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [RAM_SIZE];

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;

    logic                  accept;
    logic                  in_range;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Request decode; the sweep owns the write port whenever it is running.
    always_comb begin
        req_ready   = (state_q == ST_IDLE) && !clear_req;
        accept      = req_valid && req_ready;
        in_range    = {1'b0, req_addr} < SIZE_CMP;
        mem_we      = 1'b0;
        mem_waddr   = clr_ptr_q;
        mem_wdata   = INIT_VALUE;
        rsp_rdata_d = rsp_rdata_q;
        if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (accept && req_wr && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = req_addr;
            mem_wdata = req_wdata;
        end
        if (accept && !req_wr) begin
            rsp_rdata_d = in_range ? mem_q[PTR_W'(req_addr)] : '0;
        end
    end

    // Storage has no reset; contents are only initialised by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[PTR_W'(mem_waddr)] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && !in_range;
            rsp_rdata_q <= rsp_rdata_d;
            case (state_q)
                ST_CLEAR: begin
                    if (clr_ptr_q == LAST_PTR) begin
                        clr_ptr_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q <= ST_CLEAR;
                    end
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sync_ram_sp_ctrl.sv
// Bench for sync_ram_sp_ctrl: a 16-word instance and a 12-word instance (INIT 8'h5A)
// checked against an array-based model of the memory and response rules.
module tb_sync_ram_sp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear_req = 1'b0;
    logic       v16 = 1'b0;
    logic       v12 = 1'b0;
    logic       req_wr = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;

    logic       rdy16, rv16, err16, busy16;
    logic [7:0] rd16;
    logic       rdy12, rv12, err12, busy12;
    logic [7:0] rd12;

    int total = 0;
    int bad   = 0;

    logic [7:0] m16 [16];
    logic [7:0] m12 [16];
    logic [7:0] exp_rd16;
    logic [7:0] exp_rd12;
    logic       exp_err;

    always #5 clk = ~clk;

    sync_ram_sp_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(v16), .req_ready(rdy16), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .clear_req(clear_req),
        .rsp_valid(rv16), .rsp_rdata(rd16), .rsp_err(err16), .busy(busy16)
    );

    sync_ram_sp_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_SIZE(12), .INIT_VALUE(8'h5A)) dut12 (
        .clk(clk), .rst(rst), .req_valid(v12), .req_ready(rdy12), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .clear_req(1'b0),
        .rsp_valid(rv12), .rsp_rdata(rd12), .rsp_err(err12), .busy(busy12)
    );

    // Called at a negedge with the target ready; returns at the negedge after acceptance.
    task automatic issue(input bit sel, input logic wr, input logic [3:0] a, input logic [7:0] d);
        req_wr = wr; req_addr = a; req_wdata = d;
        if (sel) v12 = 1'b1; else v16 = 1'b1;
        @(negedge clk);
        v12 = 1'b0; v16 = 1'b0;
    endtask

    // Reference: words below size are storage, others error; OOR reads return zero.
    task automatic model_step(input bit sel, input logic wr, input logic [3:0] a, input logic [7:0] d);
        int size = sel ? 12 : 16;
        exp_err = (int'(a) >= size);
        if (!exp_err) begin
            if (wr) begin
                if (sel) m12[a] = d; else m16[a] = d;
            end else begin
                if (sel) exp_rd12 = m12[a]; else exp_rd16 = m16[a];
            end
        end else if (!wr) begin
            if (sel) exp_rd12 = 8'h00; else exp_rd16 = 8'h00;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m16[i] = 8'h00;
            m12[i] = 8'h5A;
        end
        exp_rd16 = 8'h00;
        exp_rd12 = 8'h00;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy16 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rdy16 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", rdy16); end
        total++; if (rv16 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rv16); end
        total++; if (rd16 !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", rd16); end
        total++; if (err16 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err16); end
        total++; if (busy16 !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy16); end
        rst = 1'b0;
        model_reset();
        count_busy(n);
        total++; if (n != 16) begin bad++; $display("FAIL reset_sweep_len got=%0d want=16", n); end
        total++; if (rdy16 !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", rdy16); end
        for (int a = 0; a < 16; a++) begin
            model_step(1'b0, 1'b0, 4'(a), 8'h00);
            issue(1'b0, 1'b0, 4'(a), 8'h00);
            total++;
            if (rv16 !== 1'b1 || rd16 !== exp_rd16 || err16 !== 1'b0) begin
                bad++;
                $display("FAIL reset_read[%0d] got v=%b d=%h e=%b want v=1 d=%h e=0", a, rv16, rd16, err16, exp_rd16);
            end
        end
    endtask

    task automatic test_write_read();
        logic [3:0] addrs [4] = '{4'hA, 4'hB, 4'hA, 4'hB};
        logic       wrs   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] datas [4] = '{8'h0F, 8'hF0, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            model_step(1'b0, wrs[i], addrs[i], datas[i]);
            issue(1'b0, wrs[i], addrs[i], datas[i]);
            total++;
            if (rv16 !== 1'b1 || err16 !== 1'b0 || rd16 !== exp_rd16) begin
                bad++;
                $display("FAIL b2b[%0d] got v=%b d=%h e=%b want v=1 d=%h e=0", i, rv16, rd16, err16, exp_rd16);
            end
        end
        total++; if (exp_rd16 !== 8'hF0) begin bad++; $display("FAIL model_b2b got=%h want=f0", exp_rd16); end
        @(negedge clk);
        total++;
        if (rv16 !== 1'b0 || err16 !== 1'b0 || rd16 !== 8'hF0) begin
            bad++;
            $display("FAIL idle_hold got v=%b d=%h e=%b want v=0 d=f0 e=0", rv16, rd16, err16);
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0] addrs [7] = '{4'hD, 4'hD, 4'h0, 4'h0, 4'h0, 4'hB, 4'hC};
        logic       wrs   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] datas [7] = '{8'hAA, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00};
        logic       errs  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            model_step(1'b1, wrs[i], addrs[i], datas[i]);
            issue(1'b1, wrs[i], addrs[i], datas[i]);
            total++;
            if (rv12 !== 1'b1 || err12 !== errs[i] || rd12 !== exp_rd12) begin
                bad++;
                $display("FAIL oor[%0d] got v=%b d=%h e=%b want v=1 d=%h e=%b", i, rv12, rd12, err12, exp_rd12, errs[i]);
            end
        end
    endtask

    task automatic test_clear();
        int n;
        for (int a = 0; a < 16; a++) begin
            model_step(1'b0, 1'b1, 4'(a), 8'h55);
            issue(1'b0, 1'b1, 4'(a), 8'h55);
        end
        req_wr = 1'b0; req_addr = 4'h3; v16 = 1'b1; clear_req = 1'b1;
        #1;
        total++; if (rdy16 !== 1'b0) begin bad++; $display("FAIL clear_ready got=%b want=0", rdy16); end
        @(negedge clk);
        clear_req = 1'b0;
        total++; if (rv16 !== 1'b0) begin bad++; $display("FAIL clear_no_accept got=%b want=0", rv16); end
        count_busy(n);
        total++; if (n != 16) begin bad++; $display("FAIL clear_sweep_len got=%0d want=16", n); end
        total++; if (rv16 !== 1'b0) begin bad++; $display("FAIL held_early got=%b want=0", rv16); end
        @(negedge clk);
        v16 = 1'b0;
        for (int a = 0; a < 16; a++) m16[a] = 8'h00;
        model_step(1'b0, 1'b0, 4'h3, 8'h00);
        total++;
        if (rv16 !== 1'b1 || rd16 !== exp_rd16 || err16 !== 1'b0) begin
            bad++;
            $display("FAIL held_accept got v=%b d=%h e=%b want v=1 d=%h e=0", rv16, rd16, err16, exp_rd16);
        end
        for (int a = 0; a < 16; a++) begin
            model_step(1'b0, 1'b0, 4'(a), 8'h00);
            issue(1'b0, 1'b0, 4'(a), 8'h00);
            total++;
            if (rd16 !== exp_rd16) begin bad++; $display("FAIL clear_read[%0d] got=%h want=%h", a, rd16, exp_rd16); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        model_step(1'b0, 1'b1, 4'h2, 8'h9A);
        issue(1'b0, 1'b1, 4'h2, 8'h9A);
        model_step(1'b0, 1'b0, 4'h2, 8'h00);
        issue(1'b0, 1'b0, 4'h2, 8'h00);
        total++; if (rd16 !== exp_rd16) begin bad++; $display("FAIL pre_sweep_read got=%h want=%h", rd16, exp_rd16); end
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (rdy16 !== 1'b0 || rv16 !== 1'b0 || rd16 !== 8'h00 || err16 !== 1'b0 || busy16 !== 1'b1) begin
            bad++;
            $display("FAIL mid_sweep_rst got rdy=%b v=%b d=%h e=%b busy=%b want 0 0 00 0 1", rdy16, rv16, rd16, err16, busy16);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        count_busy(n);
        total++; if (n != 16) begin bad++; $display("FAIL mid_sweep_len got=%0d want=16", n); end
        model_step(1'b0, 1'b0, 4'h2, 8'h00);
        issue(1'b0, 1'b0, 4'h2, 8'h00);
        total++; if (rd16 !== exp_rd16) begin bad++; $display("FAIL post_rst_read got=%h want=%h", rd16, exp_rd16); end
        model_step(1'b1, 1'b0, 4'h4, 8'h00);
        issue(1'b1, 1'b0, 4'h4, 8'h00);
        total++; if (rd12 !== exp_rd12 || err12 !== 1'b0) begin bad++; $display("FAIL post_rst_read12 got=%h want=%h", rd12, exp_rd12); end
    endtask

    task automatic test_reset_mid_read();
        int n;
        int stale;
        model_step(1'b0, 1'b1, 4'h5, 8'h77);
        issue(1'b0, 1'b1, 4'h5, 8'h77);
        model_step(1'b0, 1'b0, 4'h5, 8'h00);
        issue(1'b0, 1'b0, 4'h5, 8'h00);
        total++; if (rv16 !== 1'b1 || rd16 !== exp_rd16) begin bad++; $display("FAIL pre_rst_read got v=%b d=%h want v=1 d=%h", rv16, rd16, exp_rd16); end
        rst = 1'b1;
        #1;
        total++; if (rv16 !== 1'b0 || rd16 !== 8'h00) begin bad++; $display("FAIL mid_read_rst got v=%b d=%h want v=0 d=00", rv16, rd16); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n = 0; stale = 0;
        while (busy16 && n < 64) begin
            if (rv16 !== 1'b0) stale++;
            n++;
            @(negedge clk);
        end
        total++; if (stale != 0 || rv16 !== 1'b0) begin bad++; $display("FAIL stale_rsp got=%0d want=0", stale); end
        total++; if (n != 16) begin bad++; $display("FAIL mid_read_sweep_len got=%0d want=16", n); end
    endtask

    task automatic test_random();
        bit         sel;
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                total++;
                if (rv16 !== 1'b0 || rv12 !== 1'b0 || err16 !== 1'b0 || err12 !== 1'b0 ||
                    rd16 !== exp_rd16 || rd12 !== exp_rd12) begin
                    bad++;
                    $display("FAIL rnd_gap[%0d] got v=%b%b e=%b%b d=%h/%h want v=00 e=00 d=%h/%h",
                             i, rv16, rv12, err16, err12, rd16, rd12, exp_rd16, exp_rd12);
                end
            end
            sel = ($urandom_range(0, 2) == 0);
            wr  = 1'($urandom);
            a   = 4'($urandom);
            d   = 8'($urandom);
            model_step(sel, wr, a, d);
            issue(sel, wr, a, d);
            total++;
            if (sel) begin
                if (rv12 !== 1'b1 || err12 !== exp_err || rd12 !== exp_rd12) begin
                    bad++;
                    $display("FAIL rnd12[%0d] wr=%b a=%h got v=%b d=%h e=%b want v=1 d=%h e=%b", i, wr, a, rv12, rd12, err12, exp_rd12, exp_err);
                end
            end else begin
                if (rv16 !== 1'b1 || err16 !== exp_err || rd16 !== exp_rd16) begin
                    bad++;
                    $display("FAIL rnd16[%0d] wr=%b a=%h got v=%b d=%h e=%b want v=1 d=%h e=%b", i, wr, a, rv16, rd16, err16, exp_rd16, exp_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_random();
        test_clear();
        test_reset_mid_sweep();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
